// File: rtl/rc4_ksa_engine_if.sv
// Key-source/controller handshake plus single-port S-box RAM bus for rc4_ksa_engine.
// master = engine side, slave = controller + RAM side.
interface rc4_ksa_engine_if #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [KEY_BYTES*8-1:0] key;
  logic [ADDR_W-1:0]      mem_q;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ADDR_W-1:0]      mem_data;
  logic                   mem_wren;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, key, mem_q,
    output mem_addr, mem_data, mem_wren, busy, done
  );

  modport slave (
    output start, key, mem_q,
    input  mem_addr, mem_data, mem_wren, busy, done
  );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine over a single-port S-box RAM (read data one cycle after address).
// Define RC4_KSA_INIT_EN to build the S[i]=i fill phase ahead of the swap loop.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic             clk,
  input  logic             reset,
  rc4_ksa_engine_if.master bus
);

  localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST    = '1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
`ifdef RC4_KSA_INIT_EN
    ST_INIT   = 4'd1,
`endif
    ST_RD_I   = 4'd2,
    ST_CAP_I  = 4'd3,
    ST_CALC_J = 4'd4,
    ST_RD_J   = 4'd5,
    ST_CAP_J  = 4'd6,
    ST_WR_I   = 4'd7,
    ST_WR_J   = 4'd8,
    ST_DONE   = 4'd9
  } state_t;

`ifdef RC4_KSA_INIT_EN
  localparam state_t ST_FIRST = ST_INIT;
`else
  localparam state_t ST_FIRST = ST_RD_I;
`endif

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [ADDR_W-1:0]      s_i_q, s_i_d;
  logic [ADDR_W-1:0]      s_j_q, s_j_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;

  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]      mem_data_q, mem_data_d;
  logic                   mem_wren_q, mem_wren_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [7:0]             key_byte;
  logic [ADDR_W-1:0]      key_term;

  // Static byte mux keeps kidx free of any modulo/variable-slice arithmetic.
  always_comb begin
    key_byte = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KIDX_W'(k)) begin
        key_byte = key_q[(KEY_BYTES - 1 - k) * 8 +: 8];
      end
    end
    key_term = ADDR_W'(key_byte);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    s_i_d   = s_i_q;
    s_j_d   = s_j_q;
    key_d   = key_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = ST_FIRST;
        end
      end
`ifdef RC4_KSA_INIT_EN
      ST_INIT: begin
        if (i_q == I_LAST) begin
          i_d     = '0;
          state_d = ST_RD_I;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
`endif
      ST_RD_I:  state_d = ST_CAP_I;
      ST_CAP_I: begin
        s_i_d   = bus.mem_q;
        state_d = ST_CALC_J;
      end
      ST_CALC_J: begin
        j_d     = j_q + s_i_q + key_term;
        state_d = ST_RD_J;
      end
      ST_RD_J:  state_d = ST_CAP_J;
      ST_CAP_J: begin
        s_j_d   = bus.mem_q;
        state_d = ST_WR_I;
      end
      ST_WR_I:  state_d = ST_WR_J;
      ST_WR_J: begin
        if (i_q == I_LAST) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
          state_d = ST_RD_I;
        end
      end
      ST_DONE: begin
        i_d     = '0;
        j_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each registered value lines up
  // with the state it belongs to, and RAM data returns in the following state.
  always_comb begin
    mem_addr_d = i_d;
    mem_data_d = '0;
    mem_wren_d = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_d)
      ST_IDLE: busy_d = 1'b0;
`ifdef RC4_KSA_INIT_EN
      ST_INIT: begin
        mem_data_d = i_d;
        mem_wren_d = 1'b1;
      end
`endif
      ST_RD_J, ST_CAP_J: mem_addr_d = j_d;
      ST_WR_I: begin
        mem_data_d = s_j_d;
        mem_wren_d = 1'b1;
      end
      ST_WR_J: begin
        mem_addr_d = j_d;
        mem_data_d = s_i_d;
        mem_wren_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      s_i_q      <= '0;
      s_j_q      <= '0;
      key_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      kidx_q     <= kidx_d;
      s_i_q      <= s_i_d;
      s_j_q      <= s_j_d;
      key_q      <= key_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wren = mem_wren_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
